alu_op_responder: RTL and testbench

- Responder end of the ALU operation interface. The testbench driver presents operand_a, operand_b, operator and op_valid; this block executes the operation and returns result with a one-cycle operation_done pulse.
- Single-cycle logic/arithmetic ops. Iterative 32-step multiply, divide and remainder.
- Sits under alu_top as the execution engine, and doubles as a reference responder for bench self-checks.

---
 rtl/alu_op_responder.sv | 187 ++++++++++++++++++
 tb/tb_alu_op_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_responder.sv
// alu_op_responder: executes one ALU operation per accepted request.
// Logic, add/sub and shift opcodes finish in one cycle. Multiply, divide
// and remainder run WIDTH iterations, one shift-add or restoring-subtract
// step per clock, with busy high for the whole run.
module alu_op_responder #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [OPW-1:0]   operator,
    input  logic             op_valid,
    output logic             operation_done,
    output logic [WIDTH-1:0] result,
    output logic             op_error,
    output logic             busy
);

    localparam int CW  = $clog2(WIDTH);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_SUB = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_AND = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_OR  = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_XOR = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_SHL = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_SHR = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_MUL = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_DIV = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_REM = OPW'(8'h09);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPW-1:0]   op_q, op_d;
    // x: multiplicand (mul) or dividend shifting out / quotient shifting in (div/rem)
    logic [WIDTH-1:0] x_q, x_d;
    // y: multiplier shifting right (mul) or divisor (div/rem)
    logic [WIDTH-1:0] y_q, y_d;
    // acc: running product (mul) or partial remainder (div/rem)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    // One iteration step, computed from the current registers.
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shifted;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quot_next;

    // Datapath for a single multiply or restoring-divide step
    always_comb begin
        mul_acc_next  = y_q[0] ? (acc_q + x_q) : acc_q;
        div_shifted   = {acc_q, x_q[WIDTH-1]};
        div_ge        = (div_shifted >= {1'b0, y_q});
        // When div_ge holds the difference is below the divisor, so it fits WIDTH bits.
        div_rem_next  = div_ge ? (div_shifted[WIDTH-1:0] - y_q) : div_shifted[WIDTH-1:0];
        div_quot_next = {x_q[WIDTH-2:0], div_ge};
    end

    // Next-state and output logic for the IDLE/ITER controller
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d = operator;
                    case (operator)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                            done_d = 1'b1;
                            err_d  = 1'b0;
                            case (operator)
                                OP_ADD:  result_d = operand_a + operand_b;
                                OP_SUB:  result_d = operand_a - operand_b;
                                OP_AND:  result_d = operand_a & operand_b;
                                OP_OR:   result_d = operand_a | operand_b;
                                OP_XOR:  result_d = operand_a ^ operand_b;
                                OP_SHL:  result_d = operand_a << operand_b[SHW-1:0];
                                default: result_d = operand_a >> operand_b[SHW-1:0];
                            endcase
                        end
                        OP_MUL: begin
                            x_d     = operand_a;
                            y_d     = operand_b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ITER;
                        end
                        OP_DIV, OP_REM: begin
                            if (operand_b == '0) begin
                                // Divide-by-zero completes immediately with an error.
                                done_d   = 1'b1;
                                err_d    = 1'b1;
                                result_d = (operator == OP_DIV) ? '1 : operand_a;
                            end else begin
                                x_d     = operand_a;
                                y_d     = operand_b;
                                acc_d   = '0;
                                cnt_d   = '0;
                                state_d = ITER;
                            end
                        end
                        default: begin
                            done_d   = 1'b1;
                            err_d    = 1'b1;
                            result_d = '0;
                        end
                    endcase
                end
            end

            ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_next;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = div_rem_next;
                    x_d   = div_quot_next;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    if (op_q == OP_MUL)
                        result_d = mul_acc_next;
                    else if (op_q == OP_DIV)
                        result_d = div_quot_next;
                    else
                        result_d = div_rem_next;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any op in flight without a done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign operation_done = done_q;
    assign result         = result_q;
    assign op_error       = err_q;
    assign busy           = (state_q == ITER);

endmodule

// File: tb/tb_alu_op_responder.sv
// Directed self-checking bench for alu_op_responder (WIDTH=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_op_responder;

    localparam int W = 32;
    // Samples after the accepting edge until done is seen: single-cycle ops
    // show done on the first sample, iterative ops after WIDTH further edges.
    localparam int LAT_SINGLE = 1;
    localparam int LAT_ITER   = W + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic [7:0]    operator = '0;
    logic          op_valid = 1'b0;
    logic          operation_done;
    logic [W-1:0]  result;
    logic          op_error;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_responder #(.WIDTH(W), .OPW(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operator       (operator),
        .op_valid       (op_valid),
        .operation_done (operation_done),
        .result         (result),
        .op_error       (op_error),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op, then wait (bounded) for done; returns sample latency and busy count.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] op, output int lat, output int busy_cnt);
        operand_a = a;
        operand_b = b;
        operator  = op;
        op_valid  = 1'b1;
        tick();
        op_valid = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!operation_done && lat < 100) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (!operation_done) check_eq({tag, "_timeout"}, {31'd0, operation_done}, 32'd1);
    endtask

    // Run a single-cycle op and check latency, result, error and pulse width.
    task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [7:0] op, input logic [31:0] exp_res, input logic exp_err);
        int lat, bc;
        run_op(tag, a, b, op, lat, bc);
        check_eq({tag, "_lat"}, lat, LAT_SINGLE);
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_err"}, {31'd0, op_error}, {31'd0, exp_err});
        $display("op %s a=0x%08h b=0x%08h -> res=0x%08h err=%0d lat=%0d", tag, a, b, result, op_error, lat);
        tick();
        check_eq({tag, "_pulse"}, {31'd0, operation_done}, 32'd0);
    endtask

    // Run an iterative op and check latency, busy duration, result and error.
    task automatic iter_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] op, input logic [31:0] exp_res);
        int lat, bc;
        run_op(tag, a, b, op, lat, bc);
        check_eq({tag, "_lat"}, lat, LAT_ITER);
        check_eq({tag, "_busy"}, bc, W);
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_err"}, {31'd0, op_error}, 32'd0);
        $display("op %s a=0x%08h b=0x%08h -> res=0x%08h err=%0d lat=%0d busy=%0d", tag, a, b, result, op_error, lat, bc);
        tick();
        check_eq({tag, "_pulse"}, {31'd0, operation_done}, 32'd0);
    endtask

    // Back-to-back table
    localparam int NB = 5;
    logic [31:0] bb_a   [NB] = '{32'd1, 32'd3, 32'd1, 32'd100, 32'h000000F0};
    logic [31:0] bb_b   [NB] = '{32'd2, 32'd4, 32'h23, 32'd7, 32'h000000FF};
    logic [7:0]  bb_op  [NB] = '{8'h00, 8'h07, 8'h05, 8'h09, 8'h04};
    logic [31:0] bb_exp [NB] = '{32'd3, 32'd12, 32'd8, 32'd2, 32'h0000000F};

    initial begin
        int dones;
        int idx;
        logic [31:0] res_at_done;
        int lat_at_done;

        // Reset state
        reset = 1'b1;
        op_valid = 1'b1;   // must be ignored during reset
        operator = 8'h00;
        repeat (3) tick();
        check_eq("rst_done", {31'd0, operation_done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_err", {31'd0, op_error}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        op_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single-cycle ops
        single_op("add", 32'hFFFFFFFF, 32'h1, 8'h00, 32'h00000000, 1'b0);
        single_op("sub", 32'd3, 32'd5, 8'h01, 32'hFFFFFFFE, 1'b0);
        single_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 8'h02, 32'hF000F000, 1'b0);
        single_op("or",  32'hF0F0F0F0, 32'hFF00FF00, 8'h03, 32'hFFF0FFF0, 1'b0);
        single_op("xor", 32'hF0F0F0F0, 32'hFF00FF00, 8'h04, 32'h0FF00FF0, 1'b0);
        single_op("shl", 32'h1, 32'h23, 8'h05, 32'h00000008, 1'b0);
        single_op("shr", 32'h80000000, 32'h1F, 8'h06, 32'h00000001, 1'b0);

        // Iterative ops
        iter_op("mul", 32'h00010003, 32'h00020005, 8'h07, 32'h000B000F);
        iter_op("div", 32'd100, 32'd7, 8'h08, 32'd14);
        iter_op("rem", 32'd100, 32'd7, 8'h09, 32'd2);
        iter_op("divbig", 32'hFFFFFFFF, 32'h10, 8'h08, 32'h0FFFFFFF);

        // Divide-by-zero completes in one cycle with an error
        single_op("div0", 32'd100, 32'd0, 8'h08, 32'hFFFFFFFF, 1'b1);
        single_op("rem0", 32'd5, 32'd0, 8'h09, 32'd5, 1'b1);

        // op_valid while busy is ignored
        operand_a = 32'd1000;
        operand_b = 32'd10;
        operator  = 8'h08;
        op_valid  = 1'b1;
        tick();
        op_valid = 1'b0;
        dones = 0;
        res_at_done = '0;
        lat_at_done = 0;
        for (int n = 1; n <= 45; n++) begin
            if (operation_done) begin
                dones++;
                res_at_done = result;
                lat_at_done = n;
            end
            if (n == 5 || n == 20) begin
                operand_a = 32'h12345678;
                operand_b = 32'h0000FFFF;
                operator  = 8'h04;
                op_valid  = 1'b1;
            end else begin
                op_valid = 1'b0;
            end
            tick();
        end
        check_eq("ign_dones", dones, 1);
        check_eq("ign_res", res_at_done, 32'd100);
        check_eq("ign_lat", lat_at_done, LAT_ITER);
        $display("op ignore-busy div 1000/10 -> res=%0d dones=%0d lat=%0d", res_at_done, dones, lat_at_done);

        // Back-to-back: op_valid held high, new operands each done cycle
        idx = 0;
        dones = 0;
        operand_a = bb_a[0];
        operand_b = bb_b[0];
        operator  = bb_op[0];
        op_valid  = 1'b1;
        tick();
        for (int n = 0; n < 300 && idx < NB; n++) begin
            if (operation_done) begin
                dones++;
                check_eq($sformatf("b2b_res%0d", idx), result, bb_exp[idx]);
                $display("op b2b[%0d] op=0x%02h -> res=0x%08h", idx, bb_op[idx], result);
                idx++;
                if (idx < NB) begin
                    operand_a = bb_a[idx];
                    operand_b = bb_b[idx];
                    operator  = bb_op[idx];
                end else begin
                    op_valid = 1'b0;
                end
            end
            tick();
        end
        op_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (operation_done) dones++;
            tick();
        end
        check_eq("b2b_dones", dones, NB);

        // Reset during a multiply aborts it with no done pulse
        operand_a = 32'h00010003;
        operand_b = 32'h00020005;
        operator  = 8'h07;
        op_valid  = 1'b1;
        tick();
        op_valid = 1'b0;
        dones = 0;
        for (int n = 1; n <= 10; n++) begin
            if (operation_done) dones++;
            if (n == 10) reset = 1'b1;
            tick();
        end
        check_eq("abort_done", {31'd0, operation_done}, 32'd0);
        check_eq("abort_result", result, 32'd0);
        check_eq("abort_err", {31'd0, op_error}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        for (int n = 0; n < 40; n++) begin
            if (operation_done) dones++;
            tick();
        end
        check_eq("abort_dones", dones, 0);
        $display("op mul aborted by reset -> dones=%0d", dones);

        // Illegal opcode
        single_op("illegal", 32'h1234, 32'h5678, 8'h42, 32'd0, 1'b1);

        // Normal op clears op_error again
        single_op("add2", 32'd10, 32'd20, 8'h00, 32'd30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
